// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one synchronous memory port (registered 1-cycle read)
// between buffered debug writes, the cpu16 data port and the cpu16
// instruction port. Grants are combinational from this cycle's requests and
// state; rdy pulses are registered one cycle after the grant.
module mem_arbiter #(
    parameter int AW         = 16,
    parameter int DW         = 16,
    parameter int DBG_DEPTH  = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] ins_rd_addr,
    input  logic          ins_rd_req,
    output logic          ins_rd_rdy,
    output logic [DW-1:0] ins_rd_data,
    input  logic [AW-1:0] dat_rw_addr,
    input  logic [DW-1:0] dat_wr_data,
    input  logic          dat_rd_req,
    input  logic          dat_wr_req,
    output logic          dat_rd_rdy,
    output logic          dat_wr_rdy,
    output logic [DW-1:0] dat_rd_data,
    input  logic          dbg_we,
    input  logic [AW-1:0] dbg_waddr,
    input  logic [DW-1:0] dbg_wdata,
    output logic          dbg_ovf,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_we,
    output logic          mem_re,
    input  logic [DW-1:0] mem_rdata
);

    localparam int PW = $clog2(DBG_DEPTH);
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    typedef enum logic [2:0] {
        GNT_IDLE   = 3'd0,
        GNT_DBG    = 3'd1,
        GNT_INS    = 3'd2,
        GNT_DAT_WR = 3'd3,
        GNT_DAT_RD = 3'd4
    } grant_e;

    grant_e        grant_s;

    // Debug write FIFO; pointers carry one extra wrap bit for full/empty.
    logic [AW-1:0] fifo_addr_r [DBG_DEPTH];
    logic [DW-1:0] fifo_data_r [DBG_DEPTH];
    logic [PW:0]   wr_ptr_r;
    logic [PW:0]   rd_ptr_r;
    logic          fifo_empty_s;
    logic          fifo_full_s;
    logic          push_s;
    logic          pop_s;
    logic [AW-1:0] head_addr_s;
    logic [DW-1:0] head_data_s;

    logic          ins_elig_s;
    logic          dat_elig_s;
    logic [SW-1:0] starve_r;

    logic          ins_rdy_r;
    logic          dat_rd_rdy_r;
    logic          dat_wr_rdy_r;
    logic          dbg_ovf_r;

    assign fifo_empty_s = (wr_ptr_r == rd_ptr_r);
    assign fifo_full_s  = (wr_ptr_r[PW] != rd_ptr_r[PW]) &&
                          (wr_ptr_r[PW-1:0] == rd_ptr_r[PW-1:0]);
    assign head_addr_s  = fifo_addr_r[rd_ptr_r[PW-1:0]];
    assign head_data_s  = fifo_data_r[rd_ptr_r[PW-1:0]];

    // A port is not eligible in the cycle its own response is presented,
    // because the master has not yet had a chance to retire that request.
    assign ins_elig_s = ins_rd_req && !ins_rdy_r;
    assign dat_elig_s = (dat_rd_req || dat_wr_req) && !dat_rd_rdy_r && !dat_wr_rdy_r;

    assign pop_s  = (grant_s == GNT_DBG);
    assign push_s = dbg_we && (!fifo_full_s || pop_s);

    // Read data is a pass-through of the memory's registered output.
    assign ins_rd_data = mem_rdata;
    assign dat_rd_data = mem_rdata;

    // Reset suppresses a response that is already on its way out.
    assign ins_rd_rdy = ins_rdy_r && !reset;
    assign dat_rd_rdy = dat_rd_rdy_r && !reset;
    assign dat_wr_rdy = dat_wr_rdy_r && !reset;
    assign dbg_ovf    = dbg_ovf_r;

    // Fixed-priority grant with an anti-starvation override for fetches.
    always_comb begin
        grant_s = GNT_IDLE;
        if (reset) begin
            grant_s = GNT_IDLE;
        end else if (!fifo_empty_s) begin
            grant_s = GNT_DBG;
        end else if ((starve_r >= STARVE_LIM) && ins_elig_s) begin
            grant_s = GNT_INS;
        end else if (dat_elig_s) begin
            // A combined read+write request serves the write first.
            if (dat_wr_req) begin
                grant_s = GNT_DAT_WR;
            end else begin
                grant_s = GNT_DAT_RD;
            end
        end else if (ins_elig_s) begin
            grant_s = GNT_INS;
        end else begin
            grant_s = GNT_IDLE;
        end
    end

    // Drive the memory port from the current grant.
    always_comb begin
        mem_addr  = {AW{1'b0}};
        mem_wdata = {DW{1'b0}};
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        case (grant_s)
            GNT_DBG: begin
                mem_addr  = head_addr_s;
                mem_wdata = head_data_s;
                mem_we    = 1'b1;
            end
            GNT_INS: begin
                mem_addr = ins_rd_addr;
                mem_re   = 1'b1;
            end
            GNT_DAT_WR: begin
                mem_addr  = dat_rw_addr;
                mem_wdata = dat_wr_data;
                mem_we    = 1'b1;
            end
            GNT_DAT_RD: begin
                mem_addr = dat_rw_addr;
                mem_re   = 1'b1;
            end
            default: begin
                mem_addr  = {AW{1'b0}};
                mem_wdata = {DW{1'b0}};
                mem_we    = 1'b0;
                mem_re    = 1'b0;
            end
        endcase
    end

    // FIFO storage; contents are qualified by the pointers, so no reset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_addr_r[wr_ptr_r[PW-1:0]] <= dbg_waddr;
            fifo_data_r[wr_ptr_r[PW-1:0]] <= dbg_wdata;
        end
    end

    // Control state: FIFO pointers, overflow flag, rdy pulses, starve counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r     <= {(PW+1){1'b0}};
            rd_ptr_r     <= {(PW+1){1'b0}};
            dbg_ovf_r    <= 1'b0;
            ins_rdy_r    <= 1'b0;
            dat_rd_rdy_r <= 1'b0;
            dat_wr_rdy_r <= 1'b0;
            starve_r     <= {SW{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + (PW+1)'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + (PW+1)'(1);
            end
            if (dbg_we && !push_s) begin
                dbg_ovf_r <= 1'b1;
            end

            ins_rdy_r    <= (grant_s == GNT_INS);
            dat_rd_rdy_r <= (grant_s == GNT_DAT_RD);
            dat_wr_rdy_r <= (grant_s == GNT_DAT_WR);

            if (!ins_rd_req || (grant_s == GNT_INS)) begin
                starve_r <= {SW{1'b0}};
            end else if (ins_elig_s && (starve_r < STARVE_LIM)) begin
                starve_r <= starve_r + SW'(1);
            end else begin
                starve_r <= starve_r;
            end
        end
    end

endmodule
